seq_divider: RTL and testbench

//  Iterative radix-2 restoring divider (signed/unsigned), the inverse companion of the ALU multiply path.

---
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative radix-2 restoring divider for SDIV/UDIV in the execute stage.
//   One quotient bit per cycle over WIDTH cycles. Valid/ready handshakes on
//   both sides let the pipeline stall while a division is in flight.
//
//   Signed mode divides magnitudes and fixes the signs afterwards. The
//   quotient truncates toward zero and the remainder takes the sign of the
//   dividend. MIN / -1 wraps to MIN with remainder 0; it does not trap.
//
//   A zero divisor completes in one cycle. The result is quotient 0,
//   remainder A, and div_by_zero set.
//
//   Optional build macro: SEQ_DIV_EARLY_EXIT_EN
//     When defined, a division with |A| < |B| also skips the iteration and
//     completes in one cycle. It shares the zero-divisor shortcut. The
//     results are the same as with the macro undefined; only latency changes.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             doSigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             negative,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working registers of the iteration; they are separate from the result registers
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] dvd_q;   // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] div_q;   // divisor magnitude
  logic [CW-1:0]    count_q; // quotient bits still to produce
  logic             q_neg_q;
  logic             r_neg_q;

  // Operand preparation for the accept cycle
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero, short_path, accept, last_step;

  // Iteration step
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, q_step, q_fixed, r_fixed;
  logic             unused_msbs;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == CALC) && (count_q == CW'(1));

  // Magnitudes of the incoming operands and the one-cycle shortcut decision.
  // The magnitude of MIN is MIN itself, which reads as 2^(WIDTH-1) unsigned.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    abs_a      = A;
    abs_b      = B;
    short_path = 1'b0;
    if (doSigned && A[WIDTH-1]) abs_a = -A;
    if (doSigned && B[WIDTH-1]) abs_b = -B;
    b_zero = (B == '0);
`ifdef SEQ_DIV_EARLY_EXIT_EN
    short_path = b_zero || (abs_a < abs_b);
`else
    short_path = b_zero;
`endif
  end

  // One restoring step. Shift in the next dividend bit and subtract the
  // divisor. Keep the difference only if it did not borrow. The sign fix for
  // the final edge is computed here as well.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, div_q};
    qbit     = ~trial[WIDTH+1];
    // A kept difference is below the divisor, and a rejected shift was
    // already below it, so the top bit is zero in both cases.
    rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_step   = {dvd_q[WIDTH-2:0], qbit};
    q_fixed  = q_neg_q ? -q_step : q_step;
    r_fixed  = r_neg_q ? -rem_step : rem_step;
  end

  assign unused_msbs = trial[WIDTH] | shifted[WIDTH];

  // State register; reset aborts any division in flight
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE, with a shortcut from IDLE to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = short_path ? DONE : CALC;
      CALC:    if (count_q == CW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, publish the result on the
  // edge that enters DONE, and drop out_valid once the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the working registers are reset as well. They are plain flops,
    // not a memory array, so the cost is negligible and the state after
    // reset is deterministic.
    if (!reset_n) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      count_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      rem_q       <= '0;
      dvd_q       <= abs_a;
      div_q       <= abs_b;
      count_q     <= CW'(WIDTH);
      q_neg_q     <= doSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_neg_q     <= doSigned && A[WIDTH-1];
      div_by_zero <= b_zero;
      if (short_path) begin
        // The quotient is zero and the raw dividend is already the
        // correctly signed remainder
        quotient  <= '0;
        remainder <= A;
        negative  <= 1'b0;
        zero      <= 1'b1;
        out_valid <= 1'b1;
      end
    end else if (state_q == CALC) begin
      rem_q   <= rem_step;
      dvd_q   <= q_step;
      count_q <= count_q - CW'(1);
      if (last_step) begin
        quotient  <= q_fixed;
        remainder <= r_fixed;
        negative  <= q_fixed[WIDTH-1];
        zero      <= (q_fixed == '0);
        out_valid <= 1'b1;
      end
    end else if ((state_q == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed-vector bench for seq_divider (WIDTH = 64). Expected values are
//   worked out by hand. Latency is counted in clock edges after the accept
//   edge: a full division shows out_valid after 64 edges, and a one-cycle
//   completion shows it right after the accept edge (0 further edges).
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 64;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int SMALL_LAT = 0;   // |A| < |B| takes the shortcut
`else
  localparam int SMALL_LAT = 64;  // |A| < |B| runs the full iteration
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         do_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient, remainder;
  logic         negative, zero, div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (a_in),
    .B          (b_in),
    .doSigned   (do_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .negative   (negative),
    .zero       (zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Present one division, wait for out_valid (bounded), check result and latency.
  // Leaves the result pending in DONE; the caller releases it.
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic en, input logic ez, input logic edbz, input int elat);
    int lat;
    check({tag, "_ready"}, W'(in_ready), W'(1));
    a_in = a; b_in = b; do_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, W'(lat), W'(elat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_neg"}, W'(negative), W'(en));
    check({tag, "_zero"}, W'(zero), W'(ez));
    check({tag, "_dbz"}, W'(div_by_zero), W'(edbz));
  endtask

  // Take the pending result and confirm the return to IDLE
  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rel_ov"}, W'(out_valid), W'(0));
    check({tag, "_rel_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    // Reset state, observed while reset is still asserted
    #2;
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_ov", W'(out_valid), W'(0));
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_flags", W'({negative, zero, div_by_zero}), W'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset mid-CALC after 10 cycles: abort at once, then the next division is correct
    a_in = 64'd1000; b_in = 64'd3; do_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("calc_busy", W'(in_ready), W'(0));
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_ov", W'(out_valid), W'(0));
    check("midrst_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Unsigned 100 / 7
    do_div("udiv", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0, 64);
    release_result("udiv");

    // Signed -100 / 7
    do_div("sdiv_nn", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 64);
    release_result("sdiv_nn");

    // Signed 100 / -7: quotient -14, remainder +2
    do_div("sdiv_pn", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b1, 1'b0, 1'b0, 64);
    release_result("sdiv_pn");

    // Signed -7 / 2: quotient -3, remainder -1
    do_div("sdiv_m7", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64);
    release_result("sdiv_m7");

    // Signed MIN / -1 wraps to MIN
    do_div("min_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 1'b0, 64);
    release_result("min_m1");

    // Unsigned all-ones / 16
    do_div("ubig", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0,
           64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, 1'b0, 1'b0, 64);
    release_result("ubig");

    // Unsigned MIN / all-ones: A < B, so quotient is 0 and remainder is A
    do_div("ult", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, SMALL_LAT);
    release_result("ult");

    // Divide by zero: one-cycle completion
    do_div("b0", 64'd55, 64'd0, 1'b0, 64'd0, 64'd55, 1'b0, 1'b1, 1'b1, 0);
    release_result("b0");

    // div_by_zero clears on the next accept; 3/9 unsigned (shortcut when enabled)
    do_div("u3_9", 64'd3, 64'd9, 1'b0, 64'd0, 64'd3, 1'b0, 1'b1, 1'b0, SMALL_LAT);
    release_result("u3_9");

    // Hold DONE for 5 cycles with in_valid high: stable outputs, no new accept
    do_div("hold", 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, 1'b0, 1'b0, 64);
    a_in = 64'd5; b_in = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_ov", i), W'(out_valid), W'(1));
      check($sformatf("hold%0d_rdy", i), W'(in_ready), W'(0));
      check($sformatf("hold%0d_q", i), quotient, 64'd333);
      check($sformatf("hold%0d_r", i), remainder, 64'd1);
    end
    in_valid = 1'b0;
    release_result("hold");
    check("hold_keep_q", quotient, 64'd333);

    // Reset while a result is pending in DONE clears it asynchronously
    do_div("done_rst", 64'd1000, 64'd3, 1'b0, 64'd333, 64'd1, 1'b0, 1'b0, 1'b0, 64);
    #2;
    reset_n = 1'b0;
    #1;
    check("donerst_ov", W'(out_valid), W'(0));
    check("donerst_q", quotient, '0);
    check("donerst_rdy", W'(in_ready), W'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Recovery after the reset
    do_div("post", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0, 64);
    release_result("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
